// File: rtl/ct_had_dbg_pkg.sv
// ---------------------------------------------------------------------------
// ct_had_dbg_pkg
// Shared definitions for the HAD-side IFU debug-snapshot receiver:
//   - snapshot FSM encoding
//   - read-port word-select codes
//   - width and field offsets of the 83-bit IFU debug vector
// ---------------------------------------------------------------------------
package ct_had_dbg_pkg;

   localparam int INFO_W    = 83;

   // Field offsets inside ifu_had_debug_info
   localparam int PC_LSB    = 69;
   localparam int STALL_LSB = 52;
   localparam int STATE_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_HOLD = 2'b10
   } dbg_state_e;

   localparam logic [1:0] WSEL_LO   = 2'd0;
   localparam logic [1:0] WSEL_MID  = 2'd1;
   localparam logic [1:0] WSEL_HI   = 2'd2;
   localparam logic [1:0] WSEL_STAT = 2'd3;

endpackage

// File: rtl/ct_had_dbginfo_rdmux.sv
// ---------------------------------------------------------------------------
// ct_had_dbginfo_rdmux
// Formats the shadowed debug vector into 32-bit words and registers the
// single-outstanding read acknowledge and data.
// Ports:
//   forever_cpuclk, cpurst_b  clock / async active-low reset
//   rd_req, rd_sel            level request and word select
//   shadow                    captured debug vector
//   stat_word                 pre-packed status word (word 3)
//   rd_ack, rd_data           one-cycle ack and held read data
// ---------------------------------------------------------------------------
module ct_had_dbginfo_rdmux #(
   parameter int INFO_W = ct_had_dbg_pkg::INFO_W
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst_b,
   input  logic              rd_req,
   input  logic [1:0]        rd_sel,
   input  logic [INFO_W-1:0] shadow,
   input  logic [31:0]       stat_word,
   output logic              rd_ack,
   output logic [31:0]       rd_data
);
   import ct_had_dbg_pkg::*;

   logic [31:0] word;
   logic        rd_ack_q, rd_ack_d;
   logic [31:0] rd_data_q, rd_data_d;

   always_comb begin
      word = stat_word;
      case (rd_sel)
         WSEL_LO:   word = shadow[STATE_LSB +: 32];
         WSEL_MID:  word = shadow[STATE_LSB+32 +: 32];
         // pc_bus above the stall flags, zero-extended
         WSEL_HI:   word = 32'({shadow[INFO_W-1:PC_LSB], shadow[PC_LSB-1:64]});
         WSEL_STAT: word = stat_word;
         default:   word = stat_word;
      endcase
   end

   // The ack blocks a new sample in its own cycle, so a held request
   // yields at most one ack every two cycles.
   always_comb begin
      rd_ack_d  = rd_req && !rd_ack_q;
      rd_data_d = rd_ack_d ? word : rd_data_q;
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_ack_q  <= 1'b0;
         rd_data_q <= 32'h0;
      end else begin
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_ack  = rd_ack_q;
   assign rd_data = rd_data_q;

endmodule

// File: rtl/ct_had_ifu_dbginfo_rd.sv
// ---------------------------------------------------------------------------
// ct_had_ifu_dbginfo_rd
// Shadows the IFU debug snapshot one cycle after the debug-request
// handshake makes the IFU flop it, and serves the shadow to the HAD
// register file as 32-bit words. Tracks validity, staleness (IFU reset
// after capture) and a saturating capture count.
// Ports:
//   forever_cpuclk, cpurst_b      clock / async active-low reset
//   had_rtu_xx_jdbreq             debug request
//   rtu_ifu_xx_dbgon              core already in debug mode
//   ifu_had_debug_info            IFU registered snapshot
//   ifu_had_reset_on              IFU reset sequencing active
//   had_dbginfo_clr               clear valid flag and counter
//   had_dbginfo_rd_req/_sel       read request / word select
//   had_dbginfo_rd_ack/_data      read acknowledge / data
//   had_dbginfo_vld/_stale        snapshot status
// ---------------------------------------------------------------------------
module ct_had_ifu_dbginfo_rd #(
   parameter int INFO_W = ct_had_dbg_pkg::INFO_W,
   parameter int CNT_W  = 8
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst_b,
   input  logic              had_rtu_xx_jdbreq,
   input  logic              rtu_ifu_xx_dbgon,
   input  logic [INFO_W-1:0] ifu_had_debug_info,
   input  logic              ifu_had_reset_on,
   input  logic              had_dbginfo_clr,
   input  logic              had_dbginfo_rd_req,
   input  logic [1:0]        had_dbginfo_rd_sel,
   output logic              had_dbginfo_rd_ack,
   output logic [31:0]       had_dbginfo_rd_data,
   output logic              had_dbginfo_vld,
   output logic              had_dbginfo_stale
);
   import ct_had_dbg_pkg::*;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   dbg_state_e        state_q, state_d;
   logic [INFO_W-1:0] shadow_q, shadow_d;
   logic              vld_q, vld_d;
   logic              stale_q, stale_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ron_q, ron_d;
   logic              cap_fire;
   logic              ron_rise;
   logic [7:0]        cnt8;
   logic [31:0]       stat_word;

   // Same qualification the IFU applies before flopping its debug vector
   assign cap_fire = had_rtu_xx_jdbreq && !rtu_ifu_xx_dbgon;
   assign ron_d    = ifu_had_reset_on;
   assign ron_rise = ifu_had_reset_on && !ron_q;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      vld_d    = vld_q;
      stale_d  = stale_q;
      cnt_d    = cnt_q;
      if (ron_rise && vld_q) begin
         stale_d = 1'b1;
      end
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            // A new capture request outranks a simultaneous clear
            if (cap_fire) begin
               state_d = ST_WAIT;
            end else if (had_dbginfo_clr) begin
               state_d = ST_IDLE;
               vld_d   = 1'b0;
               stale_d = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            // IFU flop has just updated; take the snapshot now
            shadow_d = ifu_had_debug_info;
            vld_d    = 1'b1;
            stale_d  = 1'b0;
            cnt_d    = sat_inc(cnt_q);
            state_d  = ST_HOLD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         vld_q    <= 1'b0;
         stale_q  <= 1'b0;
         cnt_q    <= '0;
         ron_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         vld_q    <= vld_d;
         stale_q  <= stale_d;
         cnt_q    <= cnt_d;
         ron_q    <= ron_d;
      end
   end

   assign cnt8      = 8'(cnt_q);
   assign stat_word = {vld_q, stale_q, ifu_had_reset_on, state_q, 19'b0, cnt8};

   ct_had_dbginfo_rdmux #(.INFO_W(INFO_W)) u_rdmux (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .rd_req         (had_dbginfo_rd_req),
      .rd_sel         (had_dbginfo_rd_sel),
      .shadow         (shadow_q),
      .stat_word      (stat_word),
      .rd_ack         (had_dbginfo_rd_ack),
      .rd_data        (had_dbginfo_rd_data)
   );

   assign had_dbginfo_vld   = vld_q;
   assign had_dbginfo_stale = stale_q;

endmodule

// File: tb/tb_ct_had_ifu_dbginfo_rd.sv
module tb_ct_had_ifu_dbginfo_rd;

   logic        clk;
   logic        cpurst_b;
   logic        jdbreq;
   logic        dbgon;
   logic [82:0] info;
   logic        reset_on;
   logic        clr;
   logic        rd_req;
   logic [1:0]  rd_sel;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        vld;
   logic        stale;

   int vectors;
   int miscompares;

   // Behavioural reference state
   logic [82:0] m_shadow;
   logic        m_vld, m_stale, m_loading, m_ron_prev, m_ack;
   logic [7:0]  m_cnt;
   logic [31:0] m_data;

   ct_had_ifu_dbginfo_rd dut (
      .forever_cpuclk      (clk),
      .cpurst_b            (cpurst_b),
      .had_rtu_xx_jdbreq   (jdbreq),
      .rtu_ifu_xx_dbgon    (dbgon),
      .ifu_had_debug_info  (info),
      .ifu_had_reset_on    (reset_on),
      .had_dbginfo_clr     (clr),
      .had_dbginfo_rd_req  (rd_req),
      .had_dbginfo_rd_sel  (rd_sel),
      .had_dbginfo_rd_ack  (rd_ack),
      .had_dbginfo_rd_data (rd_data),
      .had_dbginfo_vld     (vld),
      .had_dbginfo_stale   (stale)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_shadow = '0; m_vld = 0; m_stale = 0; m_loading = 0;
      m_ron_prev = 0; m_ack = 0; m_cnt = 0; m_data = 0;
   endtask

   // Status word phase: loading cycle, otherwise valid => holding, else idle
   function automatic logic [31:0] m_word(input logic [1:0] sel);
      logic [1:0] ph;
      ph = m_loading ? 2'b01 : (m_vld ? 2'b10 : 2'b00);
      case (sel)
         2'd0:    return m_shadow[31:0];
         2'd1:    return m_shadow[63:32];
         2'd2:    return {13'b0, m_shadow[82:64]};
         default: return {m_vld, m_stale, reset_on, ph, 19'b0, m_cnt};
      endcase
   endfunction

   task automatic model_step();
      logic trig, rise, old_vld;
      logic [31:0] w;
      trig    = jdbreq && !dbgon;
      rise    = reset_on && !m_ron_prev;
      old_vld = m_vld;
      w       = m_word(rd_sel);
      if (m_loading) begin
         m_shadow  = info;
         m_vld     = 1;
         m_stale   = 0;
         m_cnt     = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
         m_loading = 0;
      end else if (trig) begin
         m_loading = 1;
         if (rise && old_vld) m_stale = 1;
      end else if (clr) begin
         m_vld = 0; m_stale = 0; m_cnt = 0;
      end else if (rise && old_vld) begin
         m_stale = 1;
      end
      if (rd_req && !m_ack) begin
         m_ack  = 1;
         m_data = w;
      end else begin
         m_ack = 0;
      end
      m_ron_prev = reset_on;
   endtask

   task automatic tick();
      @(posedge clk);
      if (cpurst_b) model_step();
      @(negedge clk);
   endtask

   task automatic rand_info(output logic [82:0] v);
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      v = t[82:0];
   endtask

   task automatic do_read(input logic [1:0] sel, output logic ack, output logic [31:0] data);
      rd_req = 1; rd_sel = sel;
      tick();
      ack = rd_ack; data = rd_data;
      rd_req = 0;
      tick();
   endtask

   task automatic capture(input logic [82:0] v);
      jdbreq = 1;
      tick();
      jdbreq = 0; info = v;
      tick();
   endtask

   task automatic test_reset();
      logic a; logic [31:0] d;
      cpurst_b = 0; jdbreq = 0; dbgon = 0; info = '0; reset_on = 0;
      clr = 0; rd_req = 0; rd_sel = 0;
      model_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({vld, stale, rd_ack, rd_data} !== 35'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got vld=%b stale=%b ack=%b data=%h, need all 0", vld, stale, rd_ack, rd_data);
      end
      cpurst_b = 1;
      tick();
      for (int s = 0; s < 4; s++) begin
         do_read(2'(s), a, d);
         vectors++;
         if (a !== 1'b1 || d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read sel%0d: got ack=%b data=%h, need ack=1 data=00000000", s, a, d);
         end
      end
   endtask

   task automatic test_capture();
      logic a; logic [31:0] d;
      logic [31:0] exp_w [4];
      exp_w[0] = 32'hEF012345; exp_w[1] = 32'h6789ABCD;
      exp_w[2] = 32'h00012345; exp_w[3] = 32'h90000001;
      jdbreq = 1; dbgon = 0;
      tick();
      jdbreq = 0; info = 83'h1_2345_6789_ABCD_EF01_2345;
      vectors++;
      if (vld !== 1'b0) begin
         miscompares++;
         $display("FAIL capture_early_vld: got %b, need 0", vld);
      end
      tick();
      vectors++;
      if (vld !== 1'b1) begin
         miscompares++;
         $display("FAIL capture_vld: got %b, need 1", vld);
      end
      for (int s = 0; s < 4; s++) begin
         do_read(2'(s), a, d);
         vectors++;
         if (a !== 1'b1 || d !== exp_w[s] || d !== m_data) begin
            miscompares++;
            $display("FAIL capture_read sel%0d: got ack=%b data=%h, need ack=1 data=%h", s, a, d, exp_w[s]);
         end
      end
   endtask

   task automatic test_dbgon_block();
      logic a; logic [31:0] d;
      clr = 1; tick(); clr = 0;
      jdbreq = 1; dbgon = 1;
      repeat (3) tick();
      vectors++;
      if (vld !== 1'b0) begin
         miscompares++;
         $display("FAIL dbgon_vld: got %b, need 0", vld);
      end
      do_read(2'd3, a, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL dbgon_status: got %h, need 00000000", d);
      end
      jdbreq = 0; dbgon = 0;
      tick();
   endtask

   task automatic test_stale();
      logic a; logic [31:0] d; logic [82:0] v;
      rand_info(v);
      capture(v);
      reset_on = 1;
      tick();
      vectors++;
      if (stale !== 1'b1 || vld !== 1'b1) begin
         miscompares++;
         $display("FAIL stale_set: got stale=%b vld=%b, need 1/1", stale, vld);
      end
      do_read(2'd3, a, d);
      vectors++;
      if (d[31:29] !== 3'b111 || d !== m_data) begin
         miscompares++;
         $display("FAIL stale_status: got %h, need %h (top bits 111)", d, m_data);
      end
      reset_on = 0;
      rand_info(v);
      capture(v);
      vectors++;
      if (stale !== 1'b0) begin
         miscompares++;
         $display("FAIL stale_clear: got %b, need 0", stale);
      end
   endtask

   task automatic test_back_to_back();
      logic prev;
      prev = 0;
      rd_req = 1; rd_sel = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (rd_ack !== ((i % 2) == 0) || rd_ack !== m_ack || (prev && rd_ack)) begin
            miscompares++;
            $display("FAIL b2b_ack cyc%0d: got %b, need %b", i + 2, rd_ack, ((i % 2) == 0));
         end
         prev = rd_ack;
      end
      rd_req = 0;
      tick();
   endtask

   task automatic test_clr_collision();
      logic a; logic [31:0] d; logic [82:0] v;
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 5; i++) begin
         rand_info(v);
         capture(v);
      end
      do_read(2'd3, a, d);
      vectors++;
      if (d[7:0] !== 8'd5) begin
         miscompares++;
         $display("FAIL collide_pre_cnt: got %0d, need 5", d[7:0]);
      end
      jdbreq = 1; clr = 1;
      tick();
      jdbreq = 0; clr = 0;
      tick();
      do_read(2'd3, a, d);
      vectors++;
      if (vld !== 1'b1 || d[7:0] !== 8'd6 || d !== m_data) begin
         miscompares++;
         $display("FAIL collide_cnt: got vld=%b status=%h, need vld=1 count 6", vld, d);
      end
   endtask

   task automatic test_saturation();
      logic a; logic [31:0] d;
      jdbreq = 1;
      for (int i = 0; i < 600; i++) begin
         info[31:0] = $urandom();
         tick();
      end
      jdbreq = 0;
      tick();
      do_read(2'd3, a, d);
      vectors++;
      if (d[7:0] !== 8'hFF || d !== m_data) begin
         miscompares++;
         $display("FAIL sat_cnt: got status=%h, need count ff", d);
      end
      clr = 1; tick(); clr = 0;
      do_read(2'd3, a, d);
      vectors++;
      if (vld !== 1'b0 || d !== 32'h0) begin
         miscompares++;
         $display("FAIL sat_clr: got vld=%b status=%h, need 0/00000000", vld, d);
      end
   endtask

   task automatic test_reset_in_wait();
      logic a; logic [31:0] d; logic [82:0] v;
      rand_info(v);
      capture(v);
      jdbreq = 1;
      tick();
      rand_info(v);
      info = v; jdbreq = 0;
      #2 cpurst_b = 0;
      model_reset();
      #1;
      vectors++;
      if ({vld, stale, rd_ack, rd_data} !== 35'h0) begin
         miscompares++;
         $display("FAIL rstwait_async: got vld=%b stale=%b ack=%b data=%h, need all 0", vld, stale, rd_ack, rd_data);
      end
      rd_req = 1; rd_sel = 0;
      @(negedge clk);
      tick();
      vectors++;
      if (rd_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL rstwait_noack: got %b, need 0", rd_ack);
      end
      cpurst_b = 1;
      tick();
      a = rd_ack; d = rd_data;
      rd_req = 0;
      tick();
      vectors++;
      if (a !== 1'b1 || d !== 32'h0 || vld !== 1'b0) begin
         miscompares++;
         $display("FAIL rstwait_release: got ack=%b data=%h vld=%b, need 1/00000000/0", a, d, vld);
      end
      for (int s = 1; s < 3; s++) begin
         do_read(2'(s), a, d);
         vectors++;
         if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL rstwait_shadow sel%0d: got %h, need 00000000", s, d);
         end
      end
   endtask

   task automatic test_random();
      logic [82:0] v;
      for (int i = 0; i < 800; i++) begin
         jdbreq = ($urandom_range(3) == 0);
         dbgon  = ($urandom_range(3) == 0);
         clr    = ($urandom_range(7) == 0);
         if ($urandom_range(9) == 0) reset_on = ~reset_on;
         rand_info(v);
         info = v;
         if (rd_ack) rd_req = 0;
         else if (!rd_req && $urandom_range(1) == 1) begin
            rd_req = 1;
            rd_sel = 2'($urandom_range(3));
         end
         tick();
         vectors++;
         if (rd_ack !== m_ack || rd_data !== m_data || vld !== m_vld || stale !== m_stale) begin
            miscompares++;
            $display("FAIL random cyc%0d: got ack=%b data=%h vld=%b stale=%b, need ack=%b data=%h vld=%b stale=%b",
                     i, rd_ack, rd_data, vld, stale, m_ack, m_data, m_vld, m_stale);
         end
      end
      jdbreq = 0; dbgon = 0; clr = 0; rd_req = 0;
      tick();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_capture();
      test_dbgon_block();
      test_stale();
      test_back_to_back();
      test_clr_collision();
      test_saturation();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ct_had_ifu_dbginfo_rd.md
Name: ct_had_ifu_dbginfo_rd

Overview:
HAD-side receiver for the IFU debug snapshot bus. It watches the debug-request handshake that makes the IFU flop its 83-bit debug vector, then copies that vector into a local shadow register one cycle later. It serves the shadow to the HAD register file as 32-bit words over a single-outstanding req/ack read port, and it tracks snapshot validity, staleness and a capture count.

Parameters:
INFO_W, 83, width of ifu_had_debug_info
CNT_W, 8, width of the saturating capture counter

Ports:
forever_cpuclk  in  1  free-running core clock
cpurst_b  in  1  asynchronous active-low reset
had_rtu_xx_jdbreq  in  1  HAD debug request (the same signal seen by the IFU)
rtu_ifu_xx_dbgon  in  1  core already in debug mode
ifu_had_debug_info  in  INFO_W  IFU registered debug snapshot
ifu_had_reset_on  in  1  IFU reset-vector sequencing active
had_dbginfo_clr  in  1  clear snapshot-valid and the capture counter
had_dbginfo_rd_req  in  1  read request (level; held until ack)
had_dbginfo_rd_sel  in  2  word select, valid while rd_req
had_dbginfo_rd_ack  out  1  one-cycle read acknowledge
had_dbginfo_rd_data  out  32  read data, valid while rd_ack
had_dbginfo_vld  out  1  shadow holds a valid capture
had_dbginfo_stale  out  1  IFU reset occurred after the last capture

Behaviour:
- Clock and reset:
  - One clock, forever_cpuclk.
  - Reset cpurst_b is asynchronous, active-low.
  - All flops clear on reset: shadow=0, rd_ack=0, rd_data=0, vld=0, stale=0, counter=0, FSM=IDLE.
- Capture trigger: cap_fire = had_rtu_xx_jdbreq && !rtu_ifu_xx_dbgon, the same term the IFU uses.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: cap_fire -> WAIT.
  - WAIT: exactly one cycle. Load shadow <= ifu_had_debug_info, set vld=1, clear stale, increment counter (saturates at all-ones). -> HOLD.
  - HOLD: cap_fire -> WAIT (re-capture overwrites). had_dbginfo_clr -> IDLE with vld=0.
  - IDLE or HOLD with cap_fire and clr in the same cycle: cap_fire wins. clr is ignored, counter not cleared, next state WAIT.
  - clr in WAIT: ignored.
  - cap_fire held high for several cycles: alternates WAIT/HOLD, capturing every second cycle. Each capture counts.
- Capture latency: shadow updates 2 cycles after the cap_fire cycle, i.e. the cycle after the IFU flop updated.
- Stale flag:
  - Set on the rising edge of ifu_had_reset_on while vld=1.
  - Cleared by capture, clr, or reset.
  - Stale does not clear vld.
- Read port:
  - Only one request is outstanding at a time.
  - When rd_req=1 and rd_ack=0, the next cycle drives rd_ack=1 for one cycle with rd_data registered from the current shadow.
  - rd_req still high in the ack cycle: no new ack that cycle. The requester drops rd_req on ack.
  - Back-to-back reads therefore give acks every 2 cycles at most.
- Word map (rd_sel):
  - 0: shadow[31:0]
  - 1: shadow[63:32]
  - 2: {13'b0, shadow[82:64]}, so [18:5]=pc_bus, [4:0]=ib_ip_stall..ind_btb_stall
  - 3: {vld, stale, ifu_had_reset_on, FSM[1:0], 19'b0, counter[7:0]}
- Read/capture collision: a read sampled in the same cycle as the WAIT load returns the pre-load shadow, because both are registered on the same edge.
- Reads with vld=0 return the shadow contents (0 after reset/clr? No — clr does not zero the shadow; only reset does).
- rd_data holds its value when rd_ack=0.
- Reset mid-operation (any state): everything returns to reset values immediately. A pending rd_req gets no ack until re-sampled after reset release.

Decomposition:
- Shared package ct_had_dbg_pkg holds:
  - FSM encodings IDLE=2'b00, WAIT=2'b01, HOLD=2'b10
  - word-select constants WSEL_LO/MID/HI/STAT
  - INFO_W=83
  - field offsets of the 83-bit vector (PC_LSB=69, STALL_LSB=52, STATE_LSB=0).
- One natural sub-module, ct_had_dbginfo_rdmux: a combinational 4:1 word formatter plus the registered ack/data stage. The FSM, shadow and counter stay in the top level.

Test Plan:
- Reset then jdbreq=1 for 1 cycle with dbgon=0 and info driven to 83'h1_2345_6789_ABCD_EF01_2345 from the cycle after -> vld=1 at cycle+2, counter=1. Reads sel0=32'hEF012345, sel1=32'h6789ABCD, sel2=32'h00012345.
- jdbreq=1 with dbgon=1 -> no capture: FSM stays IDLE, vld=0, sel3 reads 32'h0.
- Capture, then pulse ifu_had_reset_on 0->1 -> stale=1 and vld=1, sel3 bits[31:29]=3'b111. A new capture then clears stale.
- rd_req held 4 cycles with sel=0 -> rd_ack pulses in cycles 2 and 4, never in consecutive cycles.
- clr and jdbreq asserted together in HOLD with counter=5 -> capture proceeds, counter=6, vld stays 1.
- 300 captures -> counter saturates at 8'hFF. Then clr -> counter=0, vld=0.
- Assert cpurst_b low during WAIT -> all outputs 0 asynchronously, and no shadow load after release.
